player_fsm: RTL and testbench

Per-player fighter controller; the producer of the player_state/player_health pair that the game-flow FSM consumes. It takes debounced button inputs, the global game_state and the opponent's state and position. It produces this player's action state, health, x position and a hit pulse. Two instances are used, cross-coupled: each instance's opp_* inputs are driven by the other instance's outputs.

---
 rtl/player_fsm.sv | 186 ++++++++++++++++++
 tb/tb_player_fsm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/player_fsm.sv
// Per-player fighter controller: action state machine, health, position and hit pulse.
// Two instances are cross-coupled through the opp_* inputs.
module player_fsm #(
  parameter int MAX_HEALTH     = 3,
  parameter int START_X        = 100,
  parameter int MIN_X          = 0,
  parameter int MAX_X          = 600,
  parameter int SPEED          = 2,
  parameter int MIN_GAP        = 32,
  parameter int ATTACK_RANGE   = 48,
  parameter int WINDUP_FRAMES  = 8,
  parameter int ACTIVE_FRAMES  = 4,
  parameter int RECOVER_FRAMES = 12,
  parameter int HITSTUN_FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       btn_block,
  input  logic [2:0] opp_state,
  input  logic [9:0] opp_pos_x,
  output logic [2:0] player_state,
  output logic [2:0] player_health,
  output logic [9:0] pos_x,
  output logic       hit_taken
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOVE    = 3'd1,
    ST_WINDUP  = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_RECOVER = 3'd4,
    ST_BLOCK   = 3'd5,
    ST_HITSTUN = 3'd6,
    ST_DEAD    = 3'd7
  } state_t;

  localparam logic [2:0] GS_FIGHT  = 3'd2;
  localparam logic [2:0] GS_P1_WIN = 3'd3;
  localparam logic [2:0] GS_P2_WIN = 3'd4;
  localparam logic [2:0] GS_EQ     = 3'd5;

  localparam logic [2:0] FULL_HEALTH = 3'(MAX_HEALTH);
  localparam logic [9:0] START_POS   = 10'(START_X);
  localparam logic [7:0] WINDUP_T    = 8'(WINDUP_FRAMES - 1);
  localparam logic [7:0] ACTIVE_T    = 8'(ACTIVE_FRAMES - 1);
  localparam logic [7:0] RECOVER_T   = 8'(RECOVER_FRAMES - 1);
  localparam logic [7:0] HITSTUN_T   = 8'(HITSTUN_FRAMES - 1);

  localparam logic signed [10:0] SPEED_S = 11'(SPEED);
  localparam logic signed [10:0] MIN_S   = 11'(MIN_X);
  localparam logic signed [10:0] MAX_S   = 11'(MAX_X);
  localparam logic signed [10:0] GAP_S   = 11'(MIN_GAP);
  localparam logic signed [10:0] RANGE_S = 11'(ATTACK_RANGE);

  function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic signed [10:0] clamp_x(input logic signed [10:0] v);
    if (v < MIN_S)      return MIN_S;
    else if (v > MAX_S) return MAX_S;
    else                return v;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  health_q, health_d;
  logic [9:0]  pos_q, pos_d;
  logic        hit_q, hit_d;
  logic [7:0]  timer_q, timer_d;
  logic        atk_q;
  logic [2:0]  opp_state_q;

  logic signed [10:0] pos_s, opp_s, cand_s, cand_gap, cur_gap;
  logic        move_blocked, opp_hit, atk_rise;
  logic [9:0]  move_pos;
  logic [2:0]  health_dec;

  assign pos_s    = signed'({1'b0, pos_q});
  assign opp_s    = signed'({1'b0, opp_pos_x});
  assign cand_s   = clamp_x(btn_right ? pos_s + SPEED_S : pos_s - SPEED_S);
  assign cand_gap = abs11(cand_s - opp_s);
  assign cur_gap  = abs11(pos_s - opp_s);
  // Only a step that closes the gap is refused; backing away is always allowed.
  assign move_blocked = (cand_gap < GAP_S) && (cand_gap < cur_gap);
  assign move_pos     = move_blocked ? pos_q : cand_s[9:0];

  // Edge-detect on the opponent's entry into ACTIVE gives one hit per attack.
  assign opp_hit    = (opp_state == 3'(ST_ACTIVE)) && (opp_state_q != 3'(ST_ACTIVE)) &&
                      (cur_gap <= RANGE_S);
  assign atk_rise   = btn_attack && !atk_q;
  assign health_dec = (health_q == 3'd0) ? 3'd0 : health_q - 3'd1;

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    pos_d    = pos_q;
    timer_d  = timer_q;
    hit_d    = 1'b0;
    case (game_state)
      GS_FIGHT: begin
        if (opp_hit && state_q != ST_BLOCK && state_q != ST_DEAD) begin
          health_d = health_dec;
          hit_d    = 1'b1;
          if (health_dec == 3'd0) begin
            state_d = ST_DEAD;
          end else begin
            state_d = ST_HITSTUN;
            timer_d = HITSTUN_T;
          end
        end else if (!opp_hit) begin
          case (state_q)
            ST_DEAD: begin
              state_d = ST_DEAD;
            end
            ST_WINDUP, ST_ACTIVE, ST_RECOVER, ST_HITSTUN: begin
              if (timer_q != 8'd0) begin
                timer_d = timer_q - 8'd1;
              end else if (state_q == ST_WINDUP) begin
                state_d = ST_ACTIVE;
                timer_d = ACTIVE_T;
              end else if (state_q == ST_ACTIVE) begin
                state_d = ST_RECOVER;
                timer_d = RECOVER_T;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default: begin
              if (atk_rise) begin
                state_d = ST_WINDUP;
                timer_d = WINDUP_T;
              end else if (btn_block) begin
                state_d = ST_BLOCK;
              end else if (btn_left ^ btn_right) begin
                state_d = ST_MOVE;
                pos_d   = move_pos;
              end else begin
                state_d = ST_IDLE;
              end
            end
          endcase
        end
      end
      GS_P1_WIN, GS_P2_WIN, GS_EQ: begin
        state_d = state_q;
      end
      default: begin
        state_d  = ST_IDLE;
        health_d = FULL_HEALTH;
        pos_d    = START_POS;
        timer_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      health_q    <= FULL_HEALTH;
      pos_q       <= START_POS;
      hit_q       <= 1'b0;
      timer_q     <= 8'd0;
      atk_q       <= 1'b0;
      opp_state_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      health_q    <= health_d;
      pos_q       <= pos_d;
      hit_q       <= hit_d;
      timer_q     <= timer_d;
      atk_q       <= btn_attack;
      opp_state_q <= opp_state;
    end
  end

  assign player_state  = state_q;
  assign player_health = health_q;
  assign pos_x         = pos_q;
  assign hit_taken     = hit_q;

endmodule

// File: tb/tb_player_fsm.sv
// Directed bench for player_fsm: attack timing, hits, block, movement and round control.
module tb_player_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] game_state;
  logic       btn_left, btn_right, btn_attack, btn_block;
  logic [2:0] opp_state;
  logic [9:0] opp_pos_x;
  logic [2:0] player_state;
  logic [2:0] player_health;
  logic [9:0] pos_x;
  logic       hit_taken;

  int checks = 0;
  int errors = 0;

  player_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .game_state   (game_state),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_attack   (btn_attack),
    .btn_block    (btn_block),
    .opp_state    (opp_state),
    .opp_pos_x    (opp_pos_x),
    .player_state (player_state),
    .player_health(player_health),
    .pos_x        (pos_x),
    .hit_taken    (hit_taken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int hp, input int px, input int hit);
    chk({tag, ".state"},  32'(player_state),  32'(st));
    chk({tag, ".health"}, 32'(player_health), 32'(hp));
    chk({tag, ".pos"},    32'(pos_x),         32'(px));
    chk({tag, ".hit"},    32'(hit_taken),     32'(hit));
  endtask

  initial begin
    reset = 1'b0; game_state = 3'd2;
    btn_left = 0; btn_right = 0; btn_attack = 0; btn_block = 0;
    opp_state = 3'd0; opp_pos_x = 10'd300;
    #1 reset = 1'b1;
    #2 chk_all("reset", 0, 3, 100, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_all("idle", 0, 3, 100, 0);

    // attack sequence, button held throughout
    btn_attack = 1;
    tick();
    for (int i = 0; i < 8; i++) begin chk("windup", 32'(player_state), 32'd2); tick(); end
    for (int i = 0; i < 4; i++) begin chk("active", 32'(player_state), 32'd3); tick(); end
    for (int i = 0; i < 12; i++) begin chk("recover", 32'(player_state), 32'd4); tick(); end
    chk("after_recover", 32'(player_state), 32'd0);
    tick();
    chk("no_retrigger", 32'(player_state), 32'd0);
    btn_attack = 0;

    // in-range hit and hitstun
    opp_pos_x = 10'd130; opp_state = 3'd3;
    tick();
    chk_all("hit1", 6, 2, 100, 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("hitstun", 32'(player_state), 32'd6);
      chk("hit_once", 32'(hit_taken), 32'd0);
    end
    tick();
    chk_all("hitstun_end", 0, 2, 100, 0);
    opp_state = 3'd0; tick();
    opp_pos_x = 10'd200; opp_state = 3'd3;
    tick();
    chk_all("out_of_range", 0, 2, 100, 0);
    opp_state = 3'd0; tick();

    // block absorbs a hit
    opp_pos_x = 10'd130; btn_block = 1;
    tick();
    chk("block_enter", 32'(player_state), 32'd5);
    opp_state = 3'd3;
    tick();
    chk_all("blocked", 5, 2, 100, 0);
    opp_state = 3'd0; btn_block = 0;
    tick();
    opp_state = 3'd3;
    tick();
    chk_all("hit2", 6, 1, 100, 1);
    opp_state = 3'd0;
    repeat (15) tick();
    chk_all("hit2_recovered", 0, 1, 100, 0);
    opp_state = 3'd3;
    tick();
    chk_all("death", 7, 0, 100, 1);
    opp_state = 3'd0; btn_attack = 1; btn_left = 1;
    tick(); tick();
    chk_all("dead_persist", 7, 0, 100, 0);
    btn_attack = 0; btn_left = 0;

    // new round, then movement
    game_state = 3'd0;
    tick();
    chk_all("reload", 0, 3, 100, 0);
    game_state = 3'd2; opp_pos_x = 10'd140; btn_right = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("move_right", 32'(pos_x), 32'(100 + 2 * i));
    end
    tick(); tick();
    chk("gap_stop", 32'(pos_x), 32'd108);
    chk("gap_state", 32'(player_state), 32'd1);
    btn_left = 1;
    tick();
    chk_all("both_dirs", 0, 3, 108, 0);
    btn_right = 0; opp_pos_x = 10'd600;
    tick();
    chk("move_left", 32'(pos_x), 32'd106);
    repeat (59) tick();
    chk("clamp_min", 32'(pos_x), 32'd0);
    chk("clamp_state", 32'(player_state), 32'd1);
    btn_left = 0;

    // freeze on match result, then reload
    tick();
    btn_attack = 1;
    tick(); tick(); tick();
    chk("windup_pre_freeze", 32'(player_state), 32'd2);
    game_state = 3'd3;
    tick();
    chk_all("freeze", 2, 3, 0, 0);
    repeat (20) tick();
    chk_all("freeze_hold", 2, 3, 0, 0);
    game_state = 3'd0;
    tick();
    chk_all("round_reload", 0, 3, 100, 0);
    btn_attack = 0; game_state = 3'd2;

    // async reset mid-ACTIVE with modified health and position
    opp_pos_x = 10'd130; opp_state = 3'd3;
    tick();
    chk("pre_hit", 32'(player_health), 32'd2);
    opp_state = 3'd0;
    repeat (15) tick();
    btn_left = 1;
    tick(); tick(); tick();
    chk("back_away", 32'(pos_x), 32'd94);
    btn_left = 0; btn_attack = 1;
    tick();
    repeat (8) tick();
    chk_all("pre_reset_active", 3, 2, 94, 0);
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 0, 3, 100, 0);
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
